emg_adc_spi_capture: RTL and testbench

Upstream acquisition stage for the EMG signal path. It periodically reads one conversion from an external serial ADC (MCP3201-class, SPI mode 0) and delivers an 8-bit sample on `d` with a one-cycle `d_valid` strobe. It drives the `d` bus that feeds the visualizer and processing unit, replacing the direct parallel input. Also covers sample-period timing, SPI clock generation, frame decoding and overrun detection.

---
 rtl/emg_adc_spi_capture.sv | 159 +++++++++++++++
 tb/tb_emg_adc_spi_capture.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/emg_adc_spi_capture.sv
// Serial ADC (MCP3201-class, SPI mode 0) capture: periodic frame read, OUT_BITS sample on d.
// Define EMG_ADC_MOVING_AVG_EN to output a 4-sample moving average instead of the raw sample.
module emg_adc_spi_capture #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned SAMPLE_DIV = 50000,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned LEAD_BITS  = 3,
  parameter int unsigned ADC_BITS   = 12,
  parameter int unsigned OUT_BITS   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                miso,
  output logic                sclk,
  output logic                cs_n,
  output logic [OUT_BITS-1:0] d,
  output logic                d_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned SCNT_W = $clog2(SAMPLE_DIV);
  localparam int unsigned HCNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BCNT_W = $clog2(FRAME_BITS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [SCNT_W-1:0]     scnt;
  logic                  tick_c;
  logic [HCNT_W-1:0]     hcnt, hcnt_nxt;
  logic [BCNT_W-1:0]     bcnt, bcnt_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt;
  logic                  sclk_nxt, cs_n_nxt, d_valid_nxt, overrun_nxt;
  logic [OUT_BITS-1:0]   d_nxt;
  logic [ADC_BITS-1:0]   word_c;
  logic [OUT_BITS-1:0]   sample_c, result_c;
  logic                  unused_c;

  // Free-running sample timer; tick on the terminal count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      scnt <= '0;
    else if (tick_c) scnt <= '0;
    else             scnt <= scnt + SCNT_W'(1);
  end

  assign tick_c   = (scnt == SCNT_W'(SAMPLE_DIV - 1));
  assign word_c   = shreg[FRAME_BITS-1-LEAD_BITS -: ADC_BITS];
  assign sample_c = word_c[ADC_BITS-1 -: OUT_BITS];

`ifdef EMG_ADC_MOVING_AVG_EN
  localparam int unsigned SUM_W = OUT_BITS + 2;
  logic [OUT_BITS-1:0] h1, h2, h3;
  logic [SUM_W-1:0]    sum_c;

  assign sum_c    = SUM_W'(sample_c) + SUM_W'(h1) + SUM_W'(h2) + SUM_W'(h3);
  assign result_c = sum_c[SUM_W-1:2];
  assign unused_c = ^{shreg, word_c, sum_c[1:0]};

  // History of the three previous truncated samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
    end else if (d_valid_nxt) begin
      h1 <= sample_c;
      h2 <= h1;
      h3 <= h2;
    end
  end
`else
  assign result_c = sample_c;
  assign unused_c = ^{shreg, word_c};
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_nxt   = state;
    hcnt_nxt    = hcnt;
    bcnt_nxt    = bcnt;
    shreg_nxt   = shreg;
    sclk_nxt    = sclk;
    cs_n_nxt    = cs_n;
    d_nxt       = d;
    d_valid_nxt = 1'b0;
    overrun_nxt = overrun | (tick_c && (state != IDLE));
    case (state)
      IDLE: begin
        cs_n_nxt = 1'b1;
        sclk_nxt = 1'b0;
        if (tick_c) begin
          state_nxt = SETUP;
          cs_n_nxt  = 1'b0;
          hcnt_nxt  = '0;
          bcnt_nxt  = '0;
        end
      end
      SETUP: begin
        if (hcnt == HCNT_W'(CLK_DIV - 1)) begin
          hcnt_nxt  = '0;
          state_nxt = SHIFT;
        end else begin
          hcnt_nxt = hcnt + HCNT_W'(1);
        end
      end
      SHIFT: begin
        if (hcnt == HCNT_W'(CLK_DIV - 1)) begin
          hcnt_nxt = '0;
          sclk_nxt = ~sclk;
          if (!sclk) begin
            shreg_nxt = {shreg[FRAME_BITS-2:0], miso};
            bcnt_nxt  = bcnt + BCNT_W'(1);
          end else if (bcnt == BCNT_W'(FRAME_BITS)) begin
            // Last falling edge: release CS and publish the sample together
            state_nxt   = DONE;
            cs_n_nxt    = 1'b1;
            d_nxt       = result_c;
            d_valid_nxt = 1'b1;
          end
        end else begin
          hcnt_nxt = hcnt + HCNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hcnt    <= '0;
      bcnt    <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      d       <= '0;
      d_valid <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      hcnt    <= hcnt_nxt;
      bcnt    <= bcnt_nxt;
      shreg   <= shreg_nxt;
      sclk    <= sclk_nxt;
      cs_n    <= cs_n_nxt;
      d       <= d_nxt;
      d_valid <= d_valid_nxt;
      busy    <= (state_nxt != IDLE);
      overrun <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_emg_adc_spi_capture.sv
// Bench for emg_adc_spi_capture: table vectors, overrun instance, mid-frame reset and random
// frames against a sample-level reference model.
module tb_emg_adc_spi_capture;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned LAT        = CLK_DIV * (1 + 2 * FRAME_BITS);

  typedef struct {
    logic [11:0] word;
    logic [7:0]  exp_d;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       miso_a = 1'b0, miso_b = 1'b0;
  logic       sclk_a, cs_n_a, d_valid_a, busy_a, overrun_a;
  logic       sclk_b, cs_n_b, d_valid_b, busy_b, overrun_b;
  logic [7:0] d_a, d_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  emg_adc_spi_capture #(.CLK_DIV(CLK_DIV), .SAMPLE_DIV(100), .FRAME_BITS(FRAME_BITS),
                        .LEAD_BITS(3), .ADC_BITS(12), .OUT_BITS(8)) dut_a (
    .clk(clk), .reset(reset), .miso(miso_a), .sclk(sclk_a), .cs_n(cs_n_a),
    .d(d_a), .d_valid(d_valid_a), .busy(busy_a), .overrun(overrun_a));

  emg_adc_spi_capture #(.CLK_DIV(CLK_DIV), .SAMPLE_DIV(40), .FRAME_BITS(FRAME_BITS),
                        .LEAD_BITS(3), .ADC_BITS(12), .OUT_BITS(8)) dut_b (
    .clk(clk), .reset(reset), .miso(miso_b), .sclk(sclk_b), .cs_n(cs_n_b),
    .d(d_b), .d_valid(d_valid_b), .busy(busy_b), .overrun(overrun_b));

  // Reference model: top 8 bits of the ADC word, optionally averaged over the last four
  int hist [3];
  function automatic int model_sample(input logic [11:0] w);
    int raw;
    int res;
    raw = int'(w) / 16;
`ifdef EMG_ADC_MOVING_AVG_EN
    res = (raw + hist[0] + hist[1] + hist[2]) / 4;
`else
    res = raw;
`endif
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = raw;
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC model for dut_a: frame = 3 zero lead bits, 12-bit word, one zero trailing bit
  logic [11:0] adc_word = 12'h000;
  logic [15:0] frame_a = 16'h0;
  int          idx_a = 0, rises_a = 0;
  logic        prev_cs_a = 1'b1, prev_sclk_a = 1'b0;
  always @(negedge clk) begin
    if (prev_cs_a && !cs_n_a) begin
      frame_a = {3'b000, adc_word, 1'b0};
      idx_a   = 0;
      rises_a = 0;
      miso_a  = frame_a[15];
    end else if (!cs_n_a && prev_sclk_a && !sclk_a) begin
      idx_a++;
      miso_a = (idx_a < 16) ? frame_a[15-idx_a] : 1'b0;
    end
    if (!prev_sclk_a && sclk_a) rises_a++;
    prev_cs_a   = cs_n_a;
    prev_sclk_a = sclk_a;
  end

  // ADC model and observers for the fast-trigger instance dut_b (word 12'h5A3)
  logic [15:0] frame_b = {3'b000, 12'h5A3, 1'b0};
  int          idx_b = 0, rises_b = 0, nb = 0, falls_b = 0, dones_b = 0, bad_b = 0;
  int          snap_falls = -1, snap_dones = -1, snap_bad = -1;
  logic [7:0]  snap_d = 8'h00;
  logic        ov79 = 1'bx, ov81 = 1'bx;
  logic        prev_cs_b = 1'b1, prev_sclk_b = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      nb = 0; falls_b = 0; dones_b = 0; bad_b = 0;
    end else begin
      nb++;
      if (prev_cs_b && !cs_n_b) begin
        idx_b = 0; rises_b = 0; miso_b = frame_b[15]; falls_b++;
      end else if (!cs_n_b && prev_sclk_b && !sclk_b) begin
        idx_b++;
        miso_b = (idx_b < 16) ? frame_b[15-idx_b] : 1'b0;
      end
      if (!prev_sclk_b && sclk_b) rises_b++;
      if (d_valid_b) begin
        dones_b++;
        if (rises_b != 16) bad_b++;
      end
      if (nb == 79) ov79 = overrun_b;
      if (nb == 81) ov81 = overrun_b;
      if (nb == 350) begin
        snap_falls = falls_b; snap_dones = dones_b; snap_bad = bad_b; snap_d = d_b;
      end
    end
    prev_cs_b   = cs_n_b;
    prev_sclk_b = sclk_b;
  end

  task automatic run_frame(input logic [11:0] w, input logic [7:0] exp_d, input string tag);
    int n;
    adc_word = w;
    n = 0;
    while (cs_n_a !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    check({tag, " cs_n_fall"}, 32'(cs_n_a), 32'd0);
    n = 0;
    while (d_valid_a !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    check({tag, " latency"}, 32'(n), 32'(LAT));
    check({tag, " d"}, 32'(d_a), 32'(exp_d));
    check({tag, " sclk_rises"}, 32'(rises_a), 32'd16);
    check({tag, " cs_n_at_valid"}, 32'(cs_n_a), 32'd1);
    check({tag, " overrun"}, 32'(overrun_a), 32'd0);
    @(negedge clk);
    check({tag, " d_valid_pulse"}, 32'(d_valid_a), 32'd0);
    check({tag, " busy_after"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    logic [11:0] w;
    int          n;
`ifdef EMG_ADC_MOVING_AVG_EN
    tbl[0] = '{12'h400, 8'h10}; tbl[1] = '{12'h800, 8'h30};
    tbl[2] = '{12'hC00, 8'h60}; tbl[3] = '{12'hFF0, 8'h9F};
    tbl[4] = '{12'hA5C, 8'hB9}; tbl[5] = '{12'hFFF, 8'hD8};
    tbl[6] = '{12'h000, 8'hA8}; tbl[7] = '{12'h01F, 8'h69};
`else
    tbl[0] = '{12'h400, 8'h40}; tbl[1] = '{12'h800, 8'h80};
    tbl[2] = '{12'hC00, 8'hC0}; tbl[3] = '{12'hFF0, 8'hFF};
    tbl[4] = '{12'hA5C, 8'hA5}; tbl[5] = '{12'hFFF, 8'hFF};
    tbl[6] = '{12'h000, 8'h00}; tbl[7] = '{12'h01F, 8'h01};
`endif
    hist = '{0, 0, 0};
    adc_word = tbl[0].word;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst cs_n", 32'(cs_n_a), 32'd1);
    check("rst sclk", 32'(sclk_a), 32'd0);
    check("rst d", 32'(d_a), 32'd0);
    check("rst d_valid", 32'(d_valid_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst overrun", 32'(overrun_a), 32'd0);
    #1 reset = 1'b1;

    repeat (99) @(negedge clk);
    check("first tick cs_n before", 32'(cs_n_a), 32'd1);
    @(negedge clk);
    check("first tick cs_n after", 32'(cs_n_a), 32'd0);

    for (int i = 0; i < 8; i++) begin
      void'(model_sample(tbl[i].word));
      run_frame(tbl[i].word, tbl[i].exp_d, $sformatf("vec%0d", i));
    end

    check("ovr before 2nd tick", 32'(ov79), 32'd0);
    check("ovr after 2nd tick", 32'(ov81), 32'd1);
    check("ovr frames started", 32'(snap_falls), 32'd4);
    check("ovr frames done", 32'(snap_dones), 32'd4);
    check("ovr malformed frames", 32'(snap_bad), 32'd0);
    check("ovr d", 32'(snap_d), 32'h5A);

    // Abort a frame after its 7th SCLK rise
    adc_word = 12'h9C3;
    n = 0;
    while (!(cs_n_a === 1'b0 && rises_a == 7) && n < 400) begin @(negedge clk); n++; end
    check("midrst rises", 32'(rises_a), 32'd7);
    #1 reset = 1'b0;
    #1;
    check("midrst cs_n", 32'(cs_n_a), 32'd1);
    check("midrst sclk", 32'(sclk_a), 32'd0);
    check("midrst d", 32'(d_a), 32'd0);
    check("midrst d_valid", 32'(d_valid_a), 32'd0);
    check("midrst busy", 32'(busy_a), 32'd0);
    repeat (5) @(negedge clk);
    check("midrst d held", 32'(d_a), 32'd0);
    hist = '{0, 0, 0};
    #1 reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      w = 12'($urandom);
      run_frame(w, 8'(model_sample(w)), $sformatf("rnd%0d", i));
    end
    check("final overrun", 32'(overrun_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
